// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, slot types and small helpers for the hazard controller.
package hazard_ctrl_pkg;

    // Operand-use marker: the instruction never reads this source.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Forwarding source selects.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Result-ready classes, counted from E entry.
    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Default mult/div occupancy in cycles.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // E slot keeps the full D snapshot; later slots only need the result timer.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } slot_e_t;

    typedef struct packed {
        logic [4:0] wreg;
        logic [1:0] tnew;
    } slot_r_t;

    // One stage of aging for the result timer, saturating at zero.
    function automatic logic [1:0] tnew_age(input logic [1:0] t);
        return (t == TNEW_PC8) ? TNEW_PC8 : t - 2'd1;
    endfunction

    // Counter width able to hold the longer of the two busy periods.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads the op length when a start sits in E,
// then counts down to zero and holds there.
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = cnt_width(MULT_CYC, DIV_CYC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    // Load on start, otherwise decrement without wrapping below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // The unit is already occupied while the start is still in E.
    always_comb begin
        busy = (count != '0) || start;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows E/M/W destination info, raises stall
// for unresolved data and HI/LO hazards, and selects forwarding sources.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] wreg_D,
    input  logic [1:0] tnew_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);

    localparam int CNT_W = cnt_width(MULT_CYC, DIV_CYC);

    slot_e_t          slot_e;
    slot_r_t          slot_m;
    slot_r_t          slot_w;
    logic [CNT_W-1:0] md_count;
    logic             haz_rs;
    logic             haz_rt;
    logic             haz_md;

    // Result still too far away for the cycle the operand is consumed.
    function automatic logic data_hazard(input logic [4:0] x, input logic [1:0] tuse,
                                         input slot_e_t e, input slot_r_t m);
        return (x != 5'd0) && (tuse != TUSE_NONE) &&
               (((x == e.wreg) && (e.tnew > tuse)) || ((x == m.wreg) && (m.tnew > tuse)));
    endfunction

    // Youngest ready producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel_d(input logic [4:0] x, input slot_e_t e,
                                             input slot_r_t m, input slot_r_t w);
        if (x == 5'd0)                               return FWD_RF;
        else if ((x == e.wreg) && (e.tnew == 2'd0))  return FWD_E;
        else if ((x == m.wreg) && (m.tnew == 2'd0))  return FWD_M;
        else if ((x == w.wreg) && (w.tnew == 2'd0))  return FWD_W;
        else                                         return FWD_RF;
    endfunction

    function automatic logic [1:0] fwd_sel_e(input logic [4:0] x,
                                             input slot_r_t m, input slot_r_t w);
        if (x == 5'd0)                               return FWD_RF;
        else if ((x == m.wreg) && (m.tnew == 2'd0))  return FWD_M;
        else if ((x == w.wreg) && (w.tnew == 2'd0))  return FWD_W;
        else                                         return FWD_RF;
    endfunction

    // Shadow pipeline: E takes D (or a bubble on stall); M and W age the timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            if (stall) begin
                slot_e <= '0;
            end else begin
                slot_e <= '{rs: rs_D, rt: rt_D, wreg: wreg_D, tnew: tnew_D,
                            md_start: md_start_D, md_div: md_div_D};
            end
            slot_m <= '{wreg: slot_e.wreg, tnew: tnew_age(slot_e.tnew)};
            slot_w <= '{wreg: slot_m.wreg, tnew: tnew_age(slot_m.tnew)};
        end
    end

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .start (slot_e.md_start),
        .div   (slot_e.md_div),
        .count (md_count),
        .busy  (md_busy)
    );

    // Hazard detection and forwarding selects, all same-cycle.
    always_comb begin
        haz_rs   = data_hazard(rs_D, tuse_rs_D, slot_e, slot_m);
        haz_rt   = data_hazard(rt_D, tuse_rt_D, slot_e, slot_m);
        haz_md   = md_use_D && ((md_count != '0) || slot_e.md_start);
        stall    = haz_rs || haz_rt || haz_md;
        fwd_rs_D = fwd_sel_d(rs_D, slot_e, slot_m, slot_w);
        fwd_rt_D = fwd_sel_d(rt_D, slot_e, slot_m, slot_w);
        fwd_rs_E = fwd_sel_e(slot_e.rs, slot_m, slot_w);
        fwd_rt_E = fwd_sel_e(slot_e.rt, slot_m, slot_w);
    end

endmodule
